bitonic_32_sched: RTL

BITONIC_32_SCHED -- requirements
Module: bitonic_32_sched

---
 rtl/topk_pkg.sv | 18 +
 rtl/topk_fifo.sv | 57 +++++
 rtl/bitonic_32_sched.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/topk_pkg.sv
// Shared types for the bitonic sort scheduler: backend control bundle,
// scheduler FSM states and the default backend latency.
package topk_pkg;

  localparam int BE_LATENCY_DEF = 5;

  typedef struct packed {
    logic vld;
    logic id;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } sched_state_e;

endpackage

// File: rtl/topk_fifo.sv
// First-word-fall-through result buffer.
// Ports: push_i/data_i write side, pop_i/data_o read side, count_o fill level.
module topk_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             full;

  // a pop on an empty buffer is not a transfer
  assign do_pop  = pop_i && (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign data_o  = mem[rptr];
  assign count_o = count;

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wptr] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_i) wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      unique case ({push_i, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (push_i && full) |-> do_pop
  );

endmodule

// File: rtl/bitonic_32_sched.sv
// Credit-based two-requester scheduler in front of a fixed-latency sort backend.
// Ports: req_* requesters, be_* backend issue/return, rsp_* results, drain_i/drain_done_o/busy_o control.
module bitonic_32_sched
  import topk_pkg::*;
#(
  parameter int DATAWIDTH  = 8,
  parameter int DATALENGTH = 32,
  parameter int BE_LATENCY = BE_LATENCY_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [1:0]                                 req_valid_i,
  output logic [1:0]                                 req_ready_o,
  input  logic [1:0][DATALENGTH-1:0][DATAWIDTH-1:0]  req_data_i,
  output ctrl_t                                      be_ctrl_o,
  output logic [DATALENGTH-1:0][DATAWIDTH-1:0]       be_x_o,
  input  ctrl_t                                      be_ctrl_i,
  input  logic [DATALENGTH-1:0][DATAWIDTH-1:0]       be_y_i,
  output logic                                       rsp_valid_o,
  input  logic                                       rsp_ready_i,
  output logic                                       rsp_id_o,
  output logic [DATALENGTH-1:0][DATAWIDTH-1:0]       rsp_data_o,
  input  logic                                       drain_i,
  output logic                                       drain_done_o,
  output logic                                       busy_o
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam int VW  = DATALENGTH * DATAWIDTH;

  sched_state_e state_q, state_n;
  logic         prio;
  logic [1:0]   gnt;
  logic         issue;
  logic         gnt_id;
  logic         ret;
  logic         can_issue;
  logic         done_q;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [CW1-1:0] used;
  ctrl_t        tag [BE_LATENCY];
  ctrl_t        tag_out;
  logic [DATALENGTH-1:0][DATAWIDTH-1:0] x_q;
  logic [VW:0]  fifo_out;

  assign used = {1'b0, inflight} + {1'b0, fifo_count};

  // drain_i blocks acceptance in the same cycle it rises
  assign can_issue = !rst_i && (state_q == RUN) && !drain_i
                     && (used < CW1'(FIFO_DEPTH));

  always_comb begin
    gnt = '0;
    if (can_issue) begin
      unique case (req_valid_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio ? 2'b10 : 2'b01;
        default: gnt = '0;
      endcase
    end
  end

  assign issue       = |gnt;
  assign gnt_id      = gnt[1];
  assign req_ready_o = gnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prio <= 1'b0;
    else if (issue) prio <= ~gnt_id;
  end

  always_ff @(posedge clk_i) begin
    if (issue) x_q <= req_data_i[gnt_id];
  end

  // tag[0] doubles as the issue register; the backend answers in tag[BE_LATENCY-1]
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BE_LATENCY; i++) tag[i] <= '0;
    end else begin
      tag[0] <= '{vld: issue, id: gnt_id};
      for (int i = 1; i < BE_LATENCY; i++) tag[i] <= tag[i-1];
    end
  end

  assign be_ctrl_o = tag[0];
  assign be_x_o    = x_q;
  assign tag_out   = tag[BE_LATENCY-1];
  assign ret       = tag_out.vld;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) inflight <= '0;
    else begin
      unique case ({issue, ret})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  topk_fifo #(
    .WIDTH (VW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ret),
    .data_i  ({tag_out.id, be_y_i}),
    .pop_i   (rsp_ready_i),
    .data_o  (fifo_out),
    .count_o (fifo_count)
  );

  assign rsp_valid_o = (fifo_count != '0);
  assign rsp_id_o    = fifo_out[VW];
  assign rsp_data_o  = fifo_out[VW-1:0];

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      RUN:     if (drain_i) state_n = DRAIN;
      DRAIN:   if (inflight == '0 && fifo_count == '0) state_n = DONE;
      DONE:    if (!drain_i) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      done_q  <= (state_q == DRAIN) && (state_n == DONE);
    end
  end

  assign drain_done_o = done_q;
  assign busy_o = (inflight != '0) || (fifo_count != '0) || tag[0].vld;

  // stale returns after a reset arrive with no tag and are simply dropped
  a_ret_match: assert property (
    @(posedge clk_i) disable iff (rst_i)
    tag_out.vld |-> (be_ctrl_i.vld && be_ctrl_i.id == tag_out.id)
  );

endmodule
